// File: rtl/id_stage_piped.sv
// id_stage_piped: ARM-subset decode, condition check, multi-port register file and ID/EX register.
// Optional macro ID_BYPASS_EN: same-cycle writeback data is forwarded into operand reads.
module id_stage_piped #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 16,
    parameter int WB_PORTS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          pc_in,
    input  logic [31:0]                    instruction,
    input  logic                           hazard,
    input  logic                           freeze,
    input  logic                           flush,
    input  logic                           z,
    input  logic                           c,
    input  logic                           v,
    input  logic                           n,
    input  logic [WB_PORTS-1:0]            wb_en,
    input  logic [4*WB_PORTS-1:0]          wb_dest,
    input  logic [DATA_WIDTH*WB_PORTS-1:0] wb_value,
    output logic [3:0]                     src1,
    output logic [3:0]                     src2,
    output logic                           two_src,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          pc_out,
    output logic                           s_out,
    output logic                           b_out,
    output logic                           mem_w_out,
    output logic                           mem_r_out,
    output logic                           wb_en_out,
    output logic [3:0]                     exe_cmd_out,
    output logic [DATA_WIDTH-1:0]          val_rn,
    output logic [DATA_WIDTH-1:0]          val_rm,
    output logic                           imm_out,
    output logic [11:0]                    shift_operand,
    output logic [23:0]                    signed_imm24,
    output logic [3:0]                     dest
);

    typedef struct packed {
        logic       s;
        logic       b;
        logic       mem_w;
        logic       mem_r;
        logic       wb_en;
        logic [3:0] exe_cmd;
    } ctrl_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        ctrl_t                 ctrl;
        logic [DATA_WIDTH-1:0] val_rn;
        logic [DATA_WIDTH-1:0] val_rm;
        logic                  imm;
        logic [11:0]           shift;
        logic [23:0]           imm24;
        logic [3:0]            dest;
    } idex_t;

    logic [3:0] cond;
    logic [1:0] mode;
    logic       i_bit;
    logic [3:0] opcode;
    logic       s_bit;
    logic       store;
    logic       cond_pass;
    ctrl_t      ctrl;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign i_bit  = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];

    always_comb begin
        ctrl = '0;
        case (mode)
            2'b00: begin
                ctrl.s     = s_bit;
                ctrl.wb_en = 1'b1;
                case (opcode)
                    4'b1101: ctrl.exe_cmd = 4'b0001;
                    4'b1111: ctrl.exe_cmd = 4'b1001;
                    4'b0100: ctrl.exe_cmd = 4'b0010;
                    4'b0101: ctrl.exe_cmd = 4'b0011;
                    4'b0010: ctrl.exe_cmd = 4'b0100;
                    4'b0110: ctrl.exe_cmd = 4'b0101;
                    4'b0000: ctrl.exe_cmd = 4'b0110;
                    4'b1100: ctrl.exe_cmd = 4'b0111;
                    4'b0001: ctrl.exe_cmd = 4'b1000;
                    4'b1010: begin
                        ctrl.exe_cmd = 4'b0100;
                        ctrl.wb_en   = 1'b0;
                    end
                    4'b1000: begin
                        ctrl.exe_cmd = 4'b0110;
                        ctrl.wb_en   = 1'b0;
                    end
                    default: ctrl = '0;
                endcase
            end
            2'b01: begin
                if (opcode == 4'b0100) begin
                    ctrl.exe_cmd = 4'b0010;
                    ctrl.mem_r   = s_bit;
                    ctrl.wb_en   = s_bit;
                    ctrl.mem_w   = ~s_bit;
                end
            end
            2'b10: ctrl.b = 1'b1;
            default: ctrl = '0;
        endcase
    end

    // A store reads its data register (Rd) through the second operand port.
    assign store   = ctrl.mem_w;
    assign src1    = instruction[19:16];
    assign src2    = store ? instruction[15:12] : instruction[3:0];
    assign two_src = ~i_bit | store;

    always_comb begin
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] rf_d [REG_COUNT];
    logic [DATA_WIDTH-1:0] rn_val;
    logic [DATA_WIDTH-1:0] rm_val;

    // Later ports overwrite earlier ones, so the highest port wins a collision.
    always_comb begin
        rf_d = rf_q;
        for (int p = 0; p < WB_PORTS; p++) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (wb_en[p] && (wb_dest[4*p +: 4] == 4'(r))) begin
                    rf_d[r] = wb_value[DATA_WIDTH*p +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    always_comb begin
        rn_val = '0;
        rm_val = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
`ifdef ID_BYPASS_EN
            if (src1 == 4'(r)) rn_val = rf_d[r];
            if (src2 == 4'(r)) rm_val = rf_d[r];
`else
            if (src1 == 4'(r)) rn_val = rf_q[r];
            if (src2 == 4'(r)) rm_val = rf_q[r];
`endif
        end
    end

    // ID/EX handshake: out_valid marks a live instruction; freeze holds the register,
    // flush and bubbles clear valid and control but never block register-file writes.
    idex_t idex_q;
    idex_t idex_d;
    idex_t captured;

    always_comb begin
        captured.valid  = 1'b1;
        captured.pc     = pc_in;
        captured.ctrl   = ctrl;
        captured.val_rn = rn_val;
        captured.val_rm = rm_val;
        captured.imm    = i_bit;
        captured.shift  = instruction[11:0];
        captured.imm24  = instruction[23:0];
        captured.dest   = instruction[15:12];

        idex_d = idex_q;
        if (flush) begin
            idex_d       = captured;
            idex_d.valid = 1'b0;
            idex_d.ctrl  = '0;
        end else if (freeze) begin
            idex_d = idex_q;
        end else if (hazard || !cond_pass || !in_valid) begin
            idex_d       = captured;
            idex_d.valid = 1'b0;
            idex_d.ctrl  = '0;
        end else begin
            idex_d = captured;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign out_valid     = idex_q.valid;
    assign pc_out        = idex_q.pc;
    assign s_out         = idex_q.ctrl.s;
    assign b_out         = idex_q.ctrl.b;
    assign mem_w_out     = idex_q.ctrl.mem_w;
    assign mem_r_out     = idex_q.ctrl.mem_r;
    assign wb_en_out     = idex_q.ctrl.wb_en;
    assign exe_cmd_out   = idex_q.ctrl.exe_cmd;
    assign val_rn        = idex_q.val_rn;
    assign val_rm        = idex_q.val_rm;
    assign imm_out       = idex_q.imm;
    assign shift_operand = idex_q.shift;
    assign signed_imm24  = idex_q.imm24;
    assign dest          = idex_q.dest;

endmodule

// File: tb/tb_id_stage_piped.sv
// tb_id_stage_piped: directed scenarios followed by randomized traffic, checked against
// an instruction-level reference model (two writeback ports, 12 architectural registers).
module tb_id_stage_piped;

    localparam int DW = 32;
    localparam int RC = 12;
    localparam int WP = 2;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   pc_in;
    logic [31:0]     instruction;
    logic            hazard, freeze, flush;
    logic            z, c, v, n;
    logic [WP-1:0]   wb_en;
    logic [4*WP-1:0] wb_dest;
    logic [DW*WP-1:0] wb_value;
    logic [3:0]      src1, src2;
    logic            two_src, out_valid;
    logic [DW-1:0]   pc_out;
    logic            s_out, b_out, mem_w_out, mem_r_out, wb_en_out;
    logic [3:0]      exe_cmd_out;
    logic [DW-1:0]   val_rn, val_rm;
    logic            imm_out;
    logic [11:0]     shift_operand;
    logic [23:0]     signed_imm24;
    logic [3:0]      dest;

    id_stage_piped #(.DATA_WIDTH(DW), .REG_COUNT(RC), .WB_PORTS(WP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in),
        .instruction(instruction), .hazard(hazard), .freeze(freeze), .flush(flush),
        .z(z), .c(c), .v(v), .n(n),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(src1), .src2(src2), .two_src(two_src), .out_valid(out_valid),
        .pc_out(pc_out), .s_out(s_out), .b_out(b_out), .mem_w_out(mem_w_out),
        .mem_r_out(mem_r_out), .wb_en_out(wb_en_out), .exe_cmd_out(exe_cmd_out),
        .val_rn(val_rn), .val_rm(val_rm), .imm_out(imm_out),
        .shift_operand(shift_operand), .signed_imm24(signed_imm24), .dest(dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model state
    logic [3:0]    alu_map [int];
    logic [3:0]    alu_ops [11] = '{4'd13, 4'd15, 4'd4, 4'd5, 4'd2, 4'd6, 4'd0, 4'd12, 4'd1, 4'd10, 4'd8};
    logic [DW-1:0] m_regs [16];
    logic          e_valid;
    logic [8:0]    e_ctrl;   // {s, b, mem_w, mem_r, wb_en, exe_cmd}
    logic [DW-1:0] e_pc, e_rn, e_rm;
    logic          e_imm;
    logic [11:0]   e_shift;
    logic [23:0]   e_imm24;
    logic [3:0]    e_dest;
    logic          e_known;

    function automatic logic [8:0] model_ctrl(input logic [31:0] ins);
        logic [1:0] mode;
        int         op;
        logic       s;
        mode = ins[27:26];
        op   = int'(ins[24:21]);
        s    = ins[20];
        if (mode == 2'd0 && alu_map.exists(op))
            return {s, 3'b000, !(op == 10 || op == 8), alu_map[op]};
        if (mode == 2'd1 && op == 4)
            return {1'b0, 1'b0, !s, s, s, 4'b0010};
        if (mode == 2'd2)
            return 9'b0_1000_0000;
        return 9'd0;
    endfunction

    // ARM style: pairs of conditions, odd code is the negation of the even one.
    function automatic logic cond_ok(input logic [3:0] cc, input logic fz, fc, fv, fn);
        logic base;
        case (cc[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        if (cc == 4'hF) return 1'b0;
        return cc[0] ? !base : base;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [3:0] idx);
        logic [DW-1:0] val;
        val = (int'(idx) < RC) ? m_regs[idx] : '0;
`ifdef ID_BYPASS_EN
        for (int p = 0; p < WP; p++)
            if (wb_en[p] && wb_dest[4*p +: 4] == idx && int'(idx) < RC)
                val = wb_value[DW*p +: DW];
`endif
        return val;
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; in_valid = 1'b0; pc_in = '0; instruction = '0;
        hazard = 1'b0; freeze = 1'b0; flush = 1'b0;
        z = 1'b0; c = 1'b0; v = 1'b0; n = 1'b0;
        wb_en = '0; wb_dest = '0; wb_value = '0;
    endtask

    task automatic set_wb(input int p, input logic [3:0] d, input logic [DW-1:0] val);
        wb_en[p] = 1'b1;
        wb_dest[4*p +: 4] = d;
        wb_value[DW*p +: DW] = val;
    endtask

    // One clock: checks combinational sources, advances the model, checks ID/EX after the edge.
    task automatic cycle();
        logic [31:0]   ins;
        logic          store, pass;
        logic [3:0]    rn_i, rm_i;
        logic [8:0]    ctl;
        logic [DW-1:0] a, b;
        #1;
        ins   = instruction;
        store = (ins[27:26] == 2'b01) && (ins[24:21] == 4'b0100) && !ins[20];
        rn_i  = ins[19:16];
        rm_i  = store ? ins[15:12] : ins[3:0];
        check_eq("src1", 64'(src1), 64'(rn_i));
        check_eq("src2", 64'(src2), 64'(rm_i));
        check_eq("two_src", 64'(two_src), 64'(!ins[25] || store));
        ctl  = model_ctrl(ins);
        a    = model_read(rn_i);
        b    = model_read(rm_i);
        pass = cond_ok(ins[31:28], z, c, v, n);
        if (rst) begin
            e_valid = 1'b0; e_ctrl = '0; e_pc = '0; e_rn = '0; e_rm = '0;
            e_imm = 1'b0; e_shift = '0; e_imm24 = '0; e_dest = '0; e_known = 1'b1;
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
        end else begin
            if (flush) begin
                e_valid = 1'b0; e_ctrl = '0; e_known = 1'b0;
            end else if (!freeze) begin
                e_pc = pc_in; e_rn = a; e_rm = b; e_imm = ins[25];
                e_shift = ins[11:0]; e_imm24 = ins[23:0]; e_dest = ins[15:12]; e_known = 1'b1;
                if (in_valid && pass && !hazard) begin
                    e_valid = 1'b1; e_ctrl = ctl;
                end else begin
                    e_valid = 1'b0; e_ctrl = '0;
                end
            end
            for (int p = 0; p < WP; p++)
                if (wb_en[p] && int'(wb_dest[4*p +: 4]) < RC)
                    m_regs[wb_dest[4*p +: 4]] = wb_value[DW*p +: DW];
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", 64'(out_valid), 64'(e_valid));
        check_eq("ctrl", 64'({s_out, b_out, mem_w_out, mem_r_out, wb_en_out, exe_cmd_out}), 64'(e_ctrl));
        if (e_known) begin
            check_eq("pc_out", 64'(pc_out), 64'(e_pc));
            check_eq("val_rn", 64'(val_rn), 64'(e_rn));
            check_eq("val_rm", 64'(val_rm), 64'(e_rm));
            check_eq("fields", 64'({imm_out, shift_operand, signed_imm24, dest}),
                     64'({e_imm, e_shift, e_imm24, e_dest}));
        end
    endtask

    initial begin
        alu_map[13] = 4'b0001; alu_map[15] = 4'b1001; alu_map[4]  = 4'b0010;
        alu_map[5]  = 4'b0011; alu_map[2]  = 4'b0100; alu_map[6]  = 4'b0101;
        alu_map[0]  = 4'b0110; alu_map[12] = 4'b0111; alu_map[1]  = 4'b1000;
        alu_map[10] = 4'b0100; alu_map[8]  = 4'b0110;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        e_valid = 1'b0; e_ctrl = '0; e_known = 1'b0;
        e_pc = '0; e_rn = '0; e_rm = '0; e_imm = 1'b0; e_shift = '0; e_imm24 = '0; e_dest = '0;

        // Reset with a pending write to R7 that must be dropped
        idle_inputs();
        rst = 1'b1;
        set_wb(0, 4'd7, 32'h77);
        cycle();
        cycle();
        check_eq("reset_valid", 64'(out_valid), 64'd0);
        check_eq("reset_pc", 64'(pc_out), 64'd0);

        idle_inputs();
        set_wb(0, 4'd2, 32'd5);
        set_wb(1, 4'd3, 32'd7);
        cycle();
        idle_inputs();
        set_wb(0, 4'd4, 32'h44);
        set_wb(1, 4'd5, 32'h55);
        cycle();

        // ADD R1,R2,R3
        idle_inputs();
        in_valid = 1'b1; pc_in = 32'h100; instruction = 32'hE082_1003;
        cycle();
        check_eq("add_valid", 64'(out_valid), 64'd1);
        check_eq("add_cmd", 64'(exe_cmd_out), 64'b0010);
        check_eq("add_wb", 64'(wb_en_out), 64'd1);
        check_eq("add_rn", 64'(val_rn), 64'd5);
        check_eq("add_rm", 64'(val_rm), 64'd7);
        check_eq("add_dest", 64'(dest), 64'd1);

        // Freeze holds the ADD while the incoming instruction changes
        for (int k = 0; k < 3; k++) begin
            freeze = 1'b1; pc_in = $urandom; instruction = 32'hE080_0000 | ($urandom & 32'h000F_FFFF);
            cycle();
        end
        check_eq("freeze_valid", 64'(out_valid), 64'd1);
        check_eq("freeze_rn", 64'(val_rn), 64'd5);
        check_eq("freeze_pc", 64'(pc_out), 64'h100);
        flush = 1'b1;
        cycle();
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        check_eq("flush_wb", 64'(wb_en_out), 64'd0);

        // STR R4,[R5]
        idle_inputs();
        in_valid = 1'b1; instruction = 32'hE485_4000;
        #1;
        check_eq("str_src2", 64'(src2), 64'd4);
        check_eq("str_two_src", 64'(two_src), 64'd1);
        cycle();
        check_eq("str_mem_w", 64'(mem_w_out), 64'd1);
        check_eq("str_wb", 64'(wb_en_out), 64'd0);
        check_eq("str_rm", 64'(val_rm), 64'h44);

        // MOVEQ R1,#5 with z clear then set
        idle_inputs();
        in_valid = 1'b1; instruction = 32'h03A0_1005; z = 1'b0;
        cycle();
        check_eq("moveq_skip_valid", 64'(out_valid), 64'd0);
        check_eq("moveq_skip_cmd", 64'(exe_cmd_out), 64'd0);
        z = 1'b1;
        cycle();
        check_eq("moveq_take_cmd", 64'(exe_cmd_out), 64'b0001);

        // Both ports write R6 while ADD R0,R6,R6 reads it
        idle_inputs();
        in_valid = 1'b1; instruction = 32'hE086_0006;
        set_wb(0, 4'd6, 32'hAA);
        set_wb(1, 4'd6, 32'hBB);
        cycle();
`ifdef ID_BYPASS_EN
        check_eq("collide_bypass_rn", 64'(val_rn), 64'hBB);
`else
        check_eq("collide_old_rn", 64'(val_rn), 64'h0);
`endif
        wb_en = '0;
        cycle();
        check_eq("collide_r6", 64'(val_rn), 64'hBB);

        // R7 write during reset was suppressed
        instruction = 32'hE087_0007;
        cycle();
        check_eq("reset_write_r7", 64'(val_rn), 64'd0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            logic [31:0] ins;
            ins = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    ins[27:26] = 2'b00;
                    if ($urandom_range(0, 5) != 0) ins[24:21] = alu_ops[$urandom_range(0, 10)];
                end
                5, 6, 7: begin
                    ins[27:26] = 2'b01;
                    if ($urandom_range(0, 4) != 0) ins[24:21] = 4'b0100;
                end
                8: ins[27:26] = 2'b10;
                default: ins[27:26] = 2'b11;
            endcase
            if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
            instruction = ins;
            pc_in    = $urandom;
            in_valid = ($urandom_range(0, 7) != 0);
            hazard   = ($urandom_range(0, 7) == 0);
            freeze   = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 59) == 0);
            {z, c, v, n} = 4'($urandom);
            wb_en    = 2'($urandom);
            wb_dest  = 8'($urandom);
            wb_value = {$urandom, $urandom};
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
